// File: rtl/pal_pkg.sv
// Shared types and constants for the palette write scheduler: FSM states,
// FIFO entry layout and the default 16-entry palette.
package pal_pkg;

  localparam int unsigned PAL_IDX_W   = 4;
  localparam int unsigned PAL_COL_W   = 6;
  localparam int unsigned PAL_ENTRIES = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWrite
  } pal_state_e;

  typedef struct packed {
    logic [PAL_IDX_W-1:0] idx;
    logic [PAL_COL_W-1:0] col;
  } pal_entry_t;

  // Entry 0 sits in the least significant bits.
  localparam logic [PAL_ENTRIES*PAL_COL_W-1:0] PAL_DEFAULTS = {
    6'h3F, 6'h3C, 6'h33, 6'h30, 6'h0F, 6'h0C, 6'h03, 6'h00,
    6'h2A, 6'h28, 6'h22, 6'h20, 6'h0A, 6'h08, 6'h02, 6'h00
  };

  function automatic logic [PAL_COL_W-1:0] pal_default(input logic [PAL_IDX_W-1:0] idx);
    return PAL_DEFAULTS[PAL_COL_W*int'(idx) +: PAL_COL_W];
  endfunction

endpackage

// File: rtl/pal_fifo.sv
// Small synchronous FIFO holding pending CPU palette writes.
// A push while full is accepted only when a pop happens in the same cycle.
module pal_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pal_wr_sched.sv
// Palette write scheduler: queues CPU writes and a default-restore sequence and
// issues them through the border index path only inside blanking windows.
module pal_wr_sched
  import pal_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_wr,
  input  logic [PAL_IDX_W-1:0] cpu_idx,
  input  logic [PAL_COL_W-1:0] cpu_color,
  input  logic                 init_req,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 hpix,
  input  logic                 vpix,
  input  logic [PAL_IDX_W-1:0] border_in,
  output logic [PAL_IDX_W-1:0] border_out,
  output logic                 wr_pal64,
  output logic [PAL_COL_W-1:0] newrealcolor,
  output logic                 cpu_full,
  output logic                 busy,
  output logic                 ovf
);

  pal_state_e           state_q, state_d;
  logic [PAL_IDX_W-1:0] tgt_idx_q, tgt_idx_d;
  logic [PAL_COL_W-1:0] tgt_col_q, tgt_col_d;
  logic                 tgt_init_q, tgt_init_d;
  logic                 init_pend_q, init_pend_d;
  logic [PAL_IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 wr_q, wr_d;
  logic [PAL_COL_W-1:0] col_q, col_d;

  logic       win;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       fifo_avail, init_acc;
  pal_entry_t fifo_rdata, fifo_wdata, fifo_next;

  assign win      = (hblank | vblank) & ~(hpix & vpix);
  assign init_acc = init_req & ~init_pend_q;

  // A FIFO entry stays queued while its write waits in SETUP, so it keeps
  // counting towards full until the write actually starts.
  assign fifo_pop   = (state_q == StSetup) & win & ~tgt_init_q;
  assign fifo_push  = cpu_wr & (~fifo_full | fifo_pop);
  assign fifo_wdata = '{idx: cpu_idx, col: cpu_color};
  // Arbitration only occurs in IDLE/WRITE, where no pop is in flight, so a
  // push into an empty FIFO becomes its head.
  assign fifo_avail = ~fifo_empty | fifo_push;
  assign fifo_next  = fifo_empty ? fifo_wdata : fifo_rdata;

  pal_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAL_IDX_W + PAL_COL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    tgt_idx_d   = tgt_idx_q;
    tgt_col_d   = tgt_col_q;
    tgt_init_d  = tgt_init_q;
    init_pend_d = init_pend_q | init_acc;
    init_cnt_d  = init_cnt_q;
    ovf_d       = ovf_q | (cpu_wr & ~fifo_push);

    unique case (state_q)
      StIdle: begin
        if (init_pend_d) begin
          state_d    = StSetup;
          tgt_idx_d  = init_cnt_q;
          tgt_col_d  = pal_default(init_cnt_q);
          tgt_init_d = 1'b1;
        end else if (fifo_avail) begin
          state_d    = StSetup;
          tgt_idx_d  = fifo_next.idx;
          tgt_col_d  = fifo_next.col;
          tgt_init_d = 1'b0;
        end
      end
      StSetup: begin
        if (win) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (tgt_init_q) begin
          init_cnt_d = init_cnt_q + 4'd1;
          if (init_cnt_q == 4'hF) begin
            init_pend_d = 1'b0;
          end
        end
        if (init_pend_d) begin
          state_d    = StSetup;
          tgt_idx_d  = init_cnt_d;
          tgt_col_d  = pal_default(init_cnt_d);
          tgt_init_d = 1'b1;
        end else if (fifo_avail) begin
          state_d    = StSetup;
          tgt_idx_d  = fifo_next.idx;
          tgt_col_d  = fifo_next.col;
          tgt_init_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // WRITE is only entered from SETUP, where the target is already stable.
    wr_d  = (state_d == StWrite);
    col_d = wr_d ? tgt_col_q : col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tgt_idx_q   <= '0;
      tgt_col_q   <= '0;
      tgt_init_q  <= 1'b0;
      init_pend_q <= 1'b0;
      init_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      wr_q        <= 1'b0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      tgt_idx_q   <= tgt_idx_d;
      tgt_col_q   <= tgt_col_d;
      tgt_init_q  <= tgt_init_d;
      init_pend_q <= init_pend_d;
      init_cnt_q  <= init_cnt_d;
      ovf_q       <= ovf_d;
      wr_q        <= wr_d;
      col_q       <= col_d;
    end
  end

  assign border_out   = ((state_q == StSetup) || (state_q == StWrite)) ? tgt_idx_q : border_in;
  assign wr_pal64     = wr_q;
  assign newrealcolor = col_q;
  assign cpu_full     = fifo_full;
  assign busy         = (state_q != StIdle) | init_pend_q | ~fifo_empty;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_pal_wr_sched.sv
// Directed bench for pal_wr_sched: single writes, blanking wait, FIFO overflow,
// default-restore sequence, arbitration and reset in mid-sequence.
module tb_pal_wr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_wr, init_req, hblank, vblank, hpix, vpix;
  logic [3:0] cpu_idx, border_in, border_out;
  logic [5:0] cpu_color, newrealcolor;
  logic       wr_pal64, cpu_full, busy, ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] got_idx [64];
  logic [5:0] got_col [64];
  int         got_cyc [64];
  int         got_n;

  logic [5:0] exp_def [16] = '{6'h00, 6'h02, 6'h08, 6'h0A, 6'h20, 6'h22, 6'h28, 6'h2A,
                               6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};

  always #5 clk = ~clk;

  pal_wr_sched #(
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_wr       (cpu_wr),
    .cpu_idx      (cpu_idx),
    .cpu_color    (cpu_color),
    .init_req     (init_req),
    .hblank       (hblank),
    .vblank       (vblank),
    .hpix         (hpix),
    .vpix         (vpix),
    .border_in    (border_in),
    .border_out   (border_out),
    .wr_pal64     (wr_pal64),
    .newrealcolor (newrealcolor),
    .cpu_full     (cpu_full),
    .busy         (busy),
    .ovf          (ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input logic open);
    hblank = open;
    vblank = 1'b0;
    hpix   = ~open;
    vpix   = 1'b1;
  endtask

  // Advance cycles from+1..to, logging every write pulse and its cycle number.
  task automatic run_collect(input int from, input int to);
    for (int c = from + 1; c <= to; c++) begin
      tick();
      if (wr_pal64 === 1'b1) begin
        if (got_n < 64) begin
          got_idx[got_n] = border_out;
          got_col[got_n] = newrealcolor;
          got_cyc[got_n] = c;
        end
        got_n++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    border_in = 4'hA;
    #1;
    total_cnt++;
    if (border_out !== 4'hA) $display("FAIL reset_border: got %h expected %h", border_out, 4'hA);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if ({wr_pal64, newrealcolor, cpu_full, busy, ovf} !== 10'b0)
      $display("FAIL reset_outputs: got wr=%b col=%h full=%b busy=%b ovf=%b expected all 0",
               wr_pal64, newrealcolor, cpu_full, busy, ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    set_window(1'b1);
    cpu_wr = 1'b1; cpu_idx = 4'd5; cpu_color = 6'h3F;
    tick();  // N+1
    cpu_wr = 1'b0;
    total_cnt++;
    if (border_out !== 4'd5 || wr_pal64 !== 1'b0)
      $display("FAIL single_n1: got border=%h wr=%b expected 5 0", border_out, wr_pal64);
    else pass_cnt++;
    tick();  // N+2
    total_cnt++;
    if (wr_pal64 !== 1'b1 || newrealcolor !== 6'h3F || border_out !== 4'd5)
      $display("FAIL single_n2: got wr=%b col=%h border=%h expected 1 3f 5",
               wr_pal64, newrealcolor, border_out);
    else pass_cnt++;
    tick();  // N+3
    total_cnt++;
    if (wr_pal64 !== 1'b0 || busy !== 1'b0 || newrealcolor !== 6'h3F || border_out !== 4'hA)
      $display("FAIL single_n3: got wr=%b busy=%b col=%h border=%h expected 0 0 3f a",
               wr_pal64, busy, newrealcolor, border_out);
    else pass_cnt++;
  endtask

  task automatic test_wait_blank;
    set_window(1'b0);
    tick();
    total_cnt++;
    if (border_out !== 4'hA) $display("FAIL wait_idle_border: got %h expected a", border_out);
    else pass_cnt++;
    cpu_wr = 1'b1; cpu_idx = 4'd2; cpu_color = 6'h15;
    tick();
    cpu_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (wr_pal64 !== 1'b0 || border_out !== 4'd2)
        $display("FAIL wait_closed_%0d: got wr=%b border=%h expected 0 2", i, wr_pal64, border_out);
      else pass_cnt++;
      tick();
    end
    set_window(1'b1);  // first blank cycle
    tick();
    total_cnt++;
    if (wr_pal64 !== 1'b1 || newrealcolor !== 6'h15 || border_out !== 4'd2)
      $display("FAIL wait_fire: got wr=%b col=%h border=%h expected 1 15 2",
               wr_pal64, newrealcolor, border_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wr_pal64 !== 1'b0 || busy !== 1'b0)
      $display("FAIL wait_done: got wr=%b busy=%b expected 0 0", wr_pal64, busy);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    set_window(1'b0);
    for (int i = 0; i < 5; i++) begin
      cpu_wr = 1'b1; cpu_idx = 4'(i + 1); cpu_color = 6'(16 + i);
      tick();
      if (i == 2) begin
        total_cnt++;
        if (cpu_full !== 1'b0) $display("FAIL ovf_full3: got %b expected 0", cpu_full);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (cpu_full !== 1'b1 || ovf !== 1'b0)
          $display("FAIL ovf_full4: got full=%b ovf=%b expected 1 0", cpu_full, ovf);
        else pass_cnt++;
      end
    end
    cpu_wr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ovf);
    else pass_cnt++;
    set_window(1'b1);
    got_n = 0;
    run_collect(0, 20);
    total_cnt++;
    if (got_n !== 4) $display("FAIL ovf_count: got %0d writes expected 4", got_n);
    else pass_cnt++;
    for (int i = 0; i < 4 && i < got_n; i++) begin
      total_cnt++;
      if (got_idx[i] !== 4'(i + 1) || got_col[i] !== 6'(16 + i))
        $display("FAIL ovf_order_%0d: got %h/%h expected %h/%h", i, got_idx[i], got_col[i],
                 4'(i + 1), 6'(16 + i));
      else pass_cnt++;
    end
    total_cnt++;
    if (ovf !== 1'b1 || busy !== 1'b0)
      $display("FAIL ovf_sticky: got ovf=%b busy=%b expected 1 0", ovf, busy);
    else pass_cnt++;
  endtask

  task automatic test_init;
    set_window(1'b1);
    got_n = 0;
    init_req = 1'b1;
    run_collect(0, 1);
    init_req = 1'b0;
    run_collect(1, 40);
    total_cnt++;
    if (got_n !== 16) $display("FAIL init_count: got %0d expected 16", got_n);
    else pass_cnt++;
    for (int i = 0; i < 16 && i < got_n; i++) begin
      total_cnt++;
      if (got_idx[i] !== 4'(i) || got_col[i] !== exp_def[i] || got_cyc[i] !== 2 * i + 2)
        $display("FAIL init_entry_%0d: got idx=%h col=%h cyc=%0d expected %h %h %0d", i,
                 got_idx[i], got_col[i], got_cyc[i], 4'(i), exp_def[i], 2 * i + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_init_and_cpu;
    set_window(1'b1);
    got_n = 0;
    init_req = 1'b1; cpu_wr = 1'b1; cpu_idx = 4'd7; cpu_color = 6'h01;
    run_collect(0, 1);
    init_req = 1'b0; cpu_wr = 1'b0;
    run_collect(1, 10);
    init_req = 1'b1;
    run_collect(10, 11);
    init_req = 1'b0;
    run_collect(11, 80);
    total_cnt++;
    if (got_n !== 17) $display("FAIL arb_count: got %0d expected 17", got_n);
    else pass_cnt++;
    for (int i = 0; i < 16 && i < got_n; i++) begin
      total_cnt++;
      if (got_idx[i] !== 4'(i) || got_col[i] !== exp_def[i])
        $display("FAIL arb_init_%0d: got %h/%h expected %h/%h", i, got_idx[i], got_col[i],
                 4'(i), exp_def[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (got_n < 17 || got_idx[16] !== 4'd7 || got_col[16] !== 6'h01 || got_cyc[16] !== 34)
      $display("FAIL arb_cpu: got n=%0d idx=%h col=%h cyc=%0d expected 7 01 34", got_n,
               got_idx[16], got_col[16], got_cyc[16]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    set_window(1'b1);
    border_in = 4'h9;
    init_req = 1'b1; cpu_wr = 1'b1; cpu_idx = 4'd9; cpu_color = 6'h11;
    tick();
    init_req = 1'b0; cpu_wr = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (wr_pal64 === 1'b1 && border_out === 4'd6) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL rstmid_reach: entry 6 write not seen within 40 cycles");
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (wr_pal64 !== 1'b0 || newrealcolor !== 6'h00 || border_out !== 4'h9)
      $display("FAIL rstmid_out: got wr=%b col=%h border=%h expected 0 00 9",
               wr_pal64, newrealcolor, border_out);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || cpu_full !== 1'b0 || ovf !== 1'b0)
      $display("FAIL rstmid_state: got busy=%b full=%b ovf=%b expected 0 0 0", busy, cpu_full, ovf);
    else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    got_n = 0;
    init_req = 1'b1;
    run_collect(0, 1);
    init_req = 1'b0;
    run_collect(1, 6);
    total_cnt++;
    if (got_n !== 3 || got_idx[0] !== 4'd0 || got_cyc[0] !== 2 || got_idx[1] !== 4'd1)
      $display("FAIL rstmid_restart: got n=%0d first=%h@%0d second=%h expected 3 0@2 1",
               got_n, got_idx[0], got_cyc[0], got_idx[1]);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_wr = 1'b0; cpu_idx = '0; cpu_color = '0; init_req = 1'b0;
    border_in = 4'hA;
    got_n = 0;
    set_window(1'b0);
    test_reset();
    test_single_write();
    test_wait_blank();
    test_overflow();
    test_init();
    test_init_and_cpu();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
